l2_bank_rr_arbiter: RTL and testbench
=====================================

// Module: l2_bank_rr_arbiter
// PURPOSE
//  Shares one L2 SRAM bank port (TCDM protocol: req/gnt, 1-cycle r_valid) among NB_MASTERS requesters with
//  round-robin fairness. Adds a bank-clear sequencer that zero-fills the bank on request. Sits between the
//  SoC interconnect master ports and one private/interleaved L2 bank wrapper.
// PARAMETERS
//  NB_MASTERS  2            number of requesters (>=2)
//  NUM_WORDS   8192         32-bit words in the bank, cleared by the sequencer
//  BASE_ADDR   32'h1C000000 byte address of word 0, driven during clear
// PORTS
//  clk_i         in  1          clock
//  rst_ni        in  1          asynchronous active-low reset
//  init_req_i    in  1          pulse/level: start bank clear (sampled in IDLE only)
//  init_busy_o   out 1          high while clear in progress
//  init_done_o   out 1          1-cycle pulse after last clear write granted
//  m_req_i       in  N          master requests
//  m_add_i       in  N x 32     master byte addresses
//  m_wen_i       in  N          1 = read, 0 = write
//  m_wdata_i     in  N x 32     write data
//  m_be_i        in  N x 4      byte enables
//  m_gnt_o       out N          grant, one-hot or zero
//  m_r_valid_o   out N          response valid, one-hot or zero
//  m_r_rdata_o   out 32         read data, broadcast to all masters
//  s_req_o       out 1          bank request
//  s_add_o       out 32         bank byte address
//  s_wen_o       out 1          bank read/write select (1 = read)
//  s_wdata_o     out 32         bank write data
//  s_be_o        out 4          bank byte enables
//  s_gnt_i       in  1          bank grant
//  s_r_valid_i   in  1          bank response valid (cycle after grant)
//  s_r_rdata_i   in  32         bank read data
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, id_q=0, rsp_pend_q=0, rsp_mask_q=0, clr_cnt=0; init_busy_o=0, init_done_o=0;
//   all m_gnt_o/m_r_valid_o=0; s_req_o=0 (outputs combinational from reset-state regs).
//  FSM: IDLE -> CLEAR when init_req_i=1; CLEAR -> IDLE when s_gnt_i=1 with clr_cnt==NUM_WORDS-1
//   (init_done_o=1 that same transition, registered, i.e. visible the cycle after the last grant).
//   init_req_i during CLEAR ignored. Reset mid-clear: back to IDLE, no done pulse, bank contents undefined.
//  IDLE arbitration (combinational, same cycle): winner = first m_req_i[k] set scanning k = rr_ptr,
//   rr_ptr+1, ... mod N. s_req_o = |m_req_i; s_add/wen/wdata/be muxed from winner; m_gnt_o[winner] = s_gnt_i.
//  rr_ptr <= (winner+1) mod N only when s_req_o & s_gnt_i; unchanged otherwise (no grant, no rotate).
//  CLEAR: m_gnt_o=0 for all; s_req_o=1, s_wen_o=0, s_be_o=4'hF, s_wdata_o=0,
//   s_add_o = BASE_ADDR + 4*clr_cnt; clr_cnt increments on s_gnt_i, cleared on CLEAR entry.
//  Response routing: on s_req_o & s_gnt_i, id_q<=winner, rsp_pend_q<=1, rsp_mask_q<=(state==CLEAR).
//   Next cycle s_r_valid_i drives m_r_valid_o[id_q] only if rsp_mask_q=0; clear-write responses dropped.
//   Write responses are forwarded (r_valid for writes, data don't-care), matching TCDM protocol.
//  Back-to-back grants every cycle supported: id_q overwritten each grant, fixed 1-cycle bank latency.
//  IDLE->CLEAR switch happens only at a cycle boundary; a response for the last master grant still
//   routes correctly in the first CLEAR cycle (id_q/rsp_mask_q captured before switch).
//  Requests held without grant must keep address/data stable; arbiter does not latch them.
//  Width: clr_cnt is $clog2(NUM_WORDS) bits; BASE_ADDR + 4*clr_cnt computed in 32 bits, no wrap expected.
// TESTING
//  1 Reset: rst_ni=0 mid-traffic -> all m_gnt_o, m_r_valid_o, s_req_o, init_busy_o = 0 immediately.
//  2 N=2, both req every cycle, s_gnt_i=1 -> grants alternate M0,M1,M0,M1; r_valid follows each by 1 cycle.
//  3 M1 only req for 3 cycles then both -> M1,M1,M1 granted, then M0 (ptr=0 after M1 grant).
//  4 s_gnt_i=0 for 2 cycles with both req -> no m_gnt_o, rr_ptr unchanged, winner stays same.
//  5 M0 write 0xDEADBEEF @BASE+0x10, read back -> m_r_rdata_o=0xDEADBEEF, m_r_valid_o=2'b01.
//  6 init_req_i pulse (NUM_WORDS=16) -> 16 writes of 0 to BASE..BASE+0x3C, masters never granted,
//    no m_r_valid_o, init_done_o pulse once; subsequent read of BASE+0x10 returns 0.

Source files
------------

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter sharing one L2 bank port (req/gnt, 1-cycle r_valid) among NB_MASTERS requesters,
// with a sequencer that zero-fills the whole bank on request.
//
//   state    | meaning
//   ---------+----------------------------------------------------------------------
//   ST_IDLE  | masters arbitrated round-robin onto the bank port
//   ST_CLEAR | bank port owned by the clear sequencer, one zero word write per grant
module l2_bank_rr_arbiter #(
    parameter int          NB_MASTERS = 2,
    parameter int          NUM_WORDS  = 8192,
    parameter logic [31:0] BASE_ADDR  = 32'h1C000000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        init_req_i,
    output logic                        init_busy_o,
    output logic                        init_done_o,
    input  logic [NB_MASTERS-1:0]       m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]       m_wen_i,
    input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NB_MASTERS-1:0][3:0]  m_be_i,
    output logic [NB_MASTERS-1:0]       m_gnt_o,
    output logic [NB_MASTERS-1:0]       m_r_valid_o,
    output logic [31:0]                 m_r_rdata_o,
    output logic                        s_req_o,
    output logic [31:0]                 s_add_o,
    output logic                        s_wen_o,
    output logic [31:0]                 s_wdata_o,
    output logic [3:0]                  s_be_o,
    input  logic                        s_gnt_i,
    input  logic                        s_r_valid_i,
    input  logic [31:0]                 s_r_rdata_i
);

    localparam int IDW  = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int CNTW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic            r_rsp_pend;
    logic            r_rsp_mask;
    logic            r_init_done;
    logic [CNTW-1:0] r_clr_cnt;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_rr_next;
    logic            w_grant;
    int              w_idx;

    // First requester at or after the round-robin pointer, wrapping modulo NB_MASTERS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NB_MASTERS;
            if (!w_found && m_req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    assign w_rr_next = IDW'((int'(w_winner) + 1) % NB_MASTERS);

    // Outputs are held quiet while reset is asserted, even if masters keep requesting.
    always_comb begin
        s_req_o   = 1'b0;
        s_add_o   = '0;
        s_wen_o   = 1'b1;
        s_wdata_o = '0;
        s_be_o    = '0;
        m_gnt_o   = '0;
        if (rst_ni) begin
            if (r_state == ST_CLEAR) begin
                s_req_o   = 1'b1;
                s_add_o   = BASE_ADDR + (32'(r_clr_cnt) << 2);
                s_wen_o   = 1'b0;
                s_wdata_o = '0;
                s_be_o    = 4'hF;
            end else begin
                s_req_o            = w_found;
                s_add_o            = m_add_i[w_winner];
                s_wen_o            = m_wen_i[w_winner];
                s_wdata_o          = m_wdata_i[w_winner];
                s_be_o             = m_be_i[w_winner];
                m_gnt_o[w_winner]  = w_found & s_gnt_i;
            end
        end
    end

    assign w_grant = s_req_o & s_gnt_i;

    always_comb begin
        m_r_valid_o = '0;
        if (s_r_valid_i && r_rsp_pend && !r_rsp_mask) begin
            m_r_valid_o[r_id] = 1'b1;
        end
    end

    assign m_r_rdata_o = s_r_rdata_i;
    assign init_busy_o = (r_state == ST_CLEAR);
    assign init_done_o = r_init_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_rsp_pend  <= 1'b0;
            r_rsp_mask  <= 1'b0;
            r_init_done <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            r_init_done <= 1'b0;
            r_rsp_pend  <= w_grant;
            // Routing is captured before any state switch so the response lands correctly next cycle.
            if (w_grant) begin
                r_id       <= w_winner;
                r_rsp_mask <= (r_state == ST_CLEAR);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_rr_ptr <= w_rr_next;
                    end
                    if (init_req_i) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (s_gnt_i) begin
                        if (r_clr_cnt == CNTW'(NUM_WORDS - 1)) begin
                            r_state     <= ST_IDLE;
                            r_init_done <= 1'b1;
                            r_clr_cnt   <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, checked against a behavioural model
// of arbitration, clear sequencing and response routing; the bench also plays the SRAM bank.
module tb_l2_bank_rr_arbiter;

    localparam int          N    = 2;
    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h1C000000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                init_req = 1'b0;
    logic                init_busy, init_done;
    logic [N-1:0]        m_req = '0, m_wen = '0;
    logic [N-1:0][31:0]  m_add = '0, m_wdata = '0;
    logic [N-1:0][3:0]   m_be = '0;
    logic [N-1:0]        m_gnt, m_rvalid;
    logic [31:0]         m_rdata;
    logic                s_req, s_wen;
    logic [31:0]         s_add, s_wdata;
    logic [3:0]          s_be;
    logic                s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0]         s_rdata = '0;

    always #5 clk = ~clk;

    l2_bank_rr_arbiter #(.NB_MASTERS(N), .NUM_WORDS(NW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .init_req_i(init_req), .init_busy_o(init_busy), .init_done_o(init_done),
        .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata), .m_be_i(m_be),
        .m_gnt_o(m_gnt), .m_r_valid_o(m_rvalid), .m_r_rdata_o(m_rdata),
        .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
        .s_gnt_i(s_gnt), .s_r_valid_i(s_rvalid), .s_r_rdata_i(s_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          ptr = 0;
    bit          busy = 0;
    int          cnt = 0;
    bit          done_q = 0;
    bit          pend_v = 0;
    int          pend_id = 0;
    bit          pend_rd = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] ref_mem  [NW];
    logic [31:0] bank_mem [NW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic set_m(input int k, input bit req, input bit wen, input int idx,
                         input logic [31:0] wd, input logic [3:0] be);
        m_req[k]   = req;
        m_wen[k]   = wen;
        m_add[k]   = BASE + 32'(4 * idx);
        m_wdata[k] = wd;
        m_be[k]    = be;
    endtask

    task automatic rand_masters();
        for (int k = 0; k < N; k++)
            set_m(k, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
                  $urandom, 4'($urandom_range(1, 15)));
    endtask

    // One clock cycle: check combinational outputs against the model, then advance bank and model.
    task automatic tick();
        int          w;
        logic [N-1:0] eg;
        logic [31:0] ea, ed, rsp;
        logic [3:0]  eb;
        bit          ew, esreq, grant, dut_hs, dut_wen_s;
        int          dut_idx, ridx;
        logic [31:0] dut_wd;
        logic [3:0]  dut_be_s;
        #2;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (w < 0 && m_req[k]) w = k;
        end
        eg = '0; ea = '0; ed = '0; eb = '0; ew = 1'b0;
        if (busy) begin
            esreq = 1'b1;
            ea    = BASE + 32'(4 * cnt);
            eb    = 4'hF;
        end else begin
            esreq = (w >= 0);
            if (w >= 0) begin
                ea = m_add[w]; ew = m_wen[w]; ed = m_wdata[w]; eb = m_be[w];
                if (s_gnt) eg[w] = 1'b1;
            end
        end
        chk("s_req", 32'(s_req), 32'(esreq));
        chk("m_gnt", 32'(m_gnt), 32'(eg));
        chk("m_r_valid", 32'(m_rvalid), pend_v ? (32'd1 << pend_id) : 32'd0);
        chk("init_busy", 32'(init_busy), 32'(busy));
        chk("init_done", 32'(init_done), 32'(done_q));
        if (esreq) begin
            chk("s_add", s_add, ea);
            chk("s_wen", 32'(s_wen), 32'(ew));
            chk("s_be", 32'(s_be), 32'(eb));
            if (!ew) chk("s_wdata", s_wdata, ed);
        end
        if (pend_v && pend_rd) chk("m_r_rdata", m_rdata, pend_data);

        dut_hs    = s_req && s_gnt;
        dut_wen_s = s_wen;
        dut_idx   = int'(((s_add - BASE) >> 2) & 32'(NW - 1));
        dut_wd    = s_wdata;
        dut_be_s  = s_be;

        @(posedge clk);
        rsp = $urandom;
        if (dut_hs) begin
            if (dut_wen_s) rsp = bank_mem[dut_idx];
            else for (int b = 0; b < 4; b++) if (dut_be_s[b]) bank_mem[dut_idx][8*b +: 8] = dut_wd[8*b +: 8];
        end

        grant   = esreq && s_gnt;
        pend_v  = grant && !busy;
        pend_id = (w < 0) ? 0 : w;
        pend_rd = ew;
        if (grant) begin
            if (busy) ref_mem[cnt] = '0;
            else begin
                ridx = int'(((ea - BASE) >> 2) & 32'(NW - 1));
                if (ew) pend_data = ref_mem[ridx];
                else for (int b = 0; b < 4; b++) if (eb[b]) ref_mem[ridx][8*b +: 8] = ed[8*b +: 8];
            end
        end
        done_q = 1'b0;
        if (busy) begin
            if (s_gnt) begin
                if (cnt == NW - 1) begin busy = 1'b0; cnt = 0; done_q = 1'b1; end
                else cnt++;
            end
        end else begin
            if (grant) ptr = (w + 1) % N;
            if (init_req) begin busy = 1'b1; cnt = 0; end
        end
        #1;
        s_rvalid = dut_hs;
        s_rdata  = rsp;
    endtask

    initial begin
        int dones;
        for (int i = 0; i < NW; i++) begin
            ref_mem[i]  = $urandom;
            bank_mem[i] = ref_mem[i];
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, no traffic
        tick();

        // Both masters request every cycle: grants alternate M0, M1, ...
        s_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_m(0, 1, 1, int'($urandom_range(0, NW - 1)), $urandom, 4'hF);
            set_m(1, 1, 1, int'($urandom_range(0, NW - 1)), $urandom, 4'hF);
            tick();
        end

        // M1 alone for three cycles, then both: M0 wins next
        set_m(0, 0, 1, 0, 0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            set_m(1, 1, 1, int'($urandom_range(0, NW - 1)), 0, 4'hF);
            tick();
        end
        set_m(0, 1, 1, 3, 0, 4'hF);
        tick();
        chk("m0_after_m1_run", 32'(m_rvalid), 32'b01);
        tick();

        // Bank stalls: no grant, pointer held
        s_gnt = 1'b0;
        tick();
        tick();
        s_gnt = 1'b1;
        tick();

        // M0 write then read back
        m_req = '0;
        set_m(0, 1, 0, 4, 32'hDEADBEEF, 4'hF);
        tick();
        set_m(0, 1, 1, 4, 0, 4'hF);
        tick();
        m_req = '0;
        #2;
        chk("readback_data", m_rdata, 32'hDEADBEEF);
        chk("readback_valid", 32'(m_rvalid), 32'b01);
        tick();

        // Bank clear with masters competing and a stuttering bank grant
        init_req = 1'b1;
        rand_masters();
        tick();
        init_req = 1'b0;
        dones = 0;
        for (int c = 0; c < 200 && busy; c++) begin
            rand_masters();
            s_gnt = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("clear_finished", 32'(init_busy), 32'd0);
        m_req = '0;
        s_gnt = 1'b1;
        #2;
        if (init_done === 1'b1) dones++;
        tick();
        #2;
        if (init_done === 1'b1) dones++;
        chk("done_pulse_count", 32'(dones), 32'd1);
        set_m(0, 1, 1, 4, 0, 4'hF);
        tick();
        m_req = '0;
        #2;
        chk("cleared_word", m_rdata, 32'h0);
        tick();

        // Random traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            rand_masters();
            s_gnt    = ($urandom_range(0, 3) != 0);
            init_req = ($urandom_range(0, 59) == 0);
            tick();
        end
        init_req = 1'b0;

        // Reset asserted mid-traffic
        set_m(0, 1, 1, 1, 0, 4'hF);
        set_m(1, 1, 0, 2, 32'h1234, 4'hF);
        s_gnt = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_m_gnt", 32'(m_gnt), 32'd0);
        chk("rst_m_r_valid", 32'(m_rvalid), 32'd0);
        chk("rst_s_req", 32'(s_req), 32'd0);
        chk("rst_init_busy", 32'(init_busy), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        ptr = 0; busy = 1'b0; cnt = 0; done_q = 1'b0; pend_v = 1'b0;
        s_rvalid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rand_masters();
            s_gnt = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
